// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register pending-write scoreboard and a registered busy count.
// Latency: reads are combinational; writes, issues and the count take effect at the next rising clk_i.
// Backpressure: none; every write and issue is accepted in the cycle it is presented.
//
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   rd_addr_i / rd_data_o / rd_busy_o     NumReadPorts packed read ports (port p at [p*W +: W])
//   wr0_* / wr1_*                         two write ports; wr1 wins on a same-index collision
//   issue_en_i / issue_addr_i             marks a destination register pending (busy)
//   pending_cnt_o                         registered number of busy registers
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
// Register 0 and indices >= NumRegs read as zero, never busy, and ignore writes and issues.

module regfile_mp #(
  parameter int NumRegs      = 32,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5,
  parameter int NumReadPorts = 3,
  localparam int CntWidth    = $clog2(NumRegs + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReadPorts*AddressWidth-1:0] rd_addr_i,
  output logic [NumReadPorts*DataWidth-1:0]    rd_data_o,
  output logic [NumReadPorts-1:0]              rd_busy_o,
  input  logic                                 wr0_en_i,
  input  logic [AddressWidth-1:0]              wr0_addr_i,
  input  logic [DataWidth-1:0]                 wr0_data_i,
  input  logic                                 wr1_en_i,
  input  logic [AddressWidth-1:0]              wr1_addr_i,
  input  logic [DataWidth-1:0]                 wr1_data_i,
  input  logic                                 issue_en_i,
  input  logic [AddressWidth-1:0]              issue_addr_i,
  output logic [CntWidth-1:0]                  pending_cnt_o
);

  if ((NumRegs > (2 ** AddressWidth)) || (NumReadPorts < 1) || (NumReadPorts > 8)) begin : g_cfg_err
    $error("regfile_mp: illegal parameter combination");
  end

  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [DataWidth-1:0] regs_d [NumRegs];
  logic [NumRegs-1:0]   busy_q;
  logic [NumRegs-1:0]   busy_d;
  logic [CntWidth-1:0]  pending_cnt_q;
  logic [CntWidth-1:0]  pending_cnt_d;

  // Loops start at 1 and stop below NumRegs, so index 0 and out-of-range
  // indices never match and are ignored without extra compare logic.
  // Statement order gives the priorities: wr1 overrides wr0, issue overrides both clears.
  always_comb begin : next_state
    regs_d        = regs_q;
    busy_d        = busy_q;
    pending_cnt_d = '0;
    for (int i = 1; i < NumRegs; i++) begin
      if (wr0_en_i && (wr0_addr_i == AddressWidth'(i))) begin
        regs_d[i] = wr0_data_i;
        busy_d[i] = 1'b0;
      end
      if (wr1_en_i && (wr1_addr_i == AddressWidth'(i))) begin
        regs_d[i] = wr1_data_i;
        busy_d[i] = 1'b0;
      end
      if (issue_en_i && (issue_addr_i == AddressWidth'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    // Population count of the next busy vector keeps the count exact by construction.
    for (int i = 0; i < NumRegs; i++) begin
      pending_cnt_d = pending_cnt_d + CntWidth'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q        <= '{default: '0};
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign pending_cnt_o = pending_cnt_q;

  always_comb begin : read_ports
    logic [AddressWidth-1:0] ra;
    rd_data_o = '0;
    rd_busy_o = '0;
    ra        = '0;
    for (int p = 0; p < NumReadPorts; p++) begin
      ra = rd_addr_i[p*AddressWidth +: AddressWidth];
      for (int i = 1; i < NumRegs; i++) begin
        if (ra == AddressWidth'(i)) begin
          rd_data_o[p*DataWidth +: DataWidth] = regs_q[i];
          rd_busy_o[p]                        = busy_q[i];
`ifdef REGFILE_MP_BYPASS_EN
          // Forwarded data is final, so the register is no longer pending unless
          // the same cycle re-issues it.
          if (wr1_en_i && (wr1_addr_i == AddressWidth'(i))) begin
            rd_data_o[p*DataWidth +: DataWidth] = wr1_data_i;
            rd_busy_o[p] = issue_en_i && (issue_addr_i == AddressWidth'(i));
          end else if (wr0_en_i && (wr0_addr_i == AddressWidth'(i))) begin
            rd_data_o[p*DataWidth +: DataWidth] = wr0_data_i;
            rd_busy_o[p] = issue_en_i && (issue_addr_i == AddressWidth'(i));
          end
`endif
        end
      end
    end
  end

endmodule
